// File: rtl/seq_pkg.sv
// Shared definitions for the serial bit-sequence path: FSM state encoding,
// len-port width derivation and the length clamp used by the pattern transmitter.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Width needed to express 0..pat_w inclusive.
    function automatic int len_width(input int pat_w);
        return $clog2(pat_w) + 1;
    endfunction

    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned pat_w);
        return (len > pat_w) ? pat_w : len;
    endfunction

endpackage

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: captures a parallel pattern and shifts it out
// MSB-first, one bit per clock, with optional back-to-back repetitions.
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int PAT_W = 8,
    parameter int LEN_W = len_width(PAT_W),
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [REP_W-1:0] reps,
    input  logic             abort,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    state_t state_q, state_d;

    logic [PAT_W-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] lc_q, lc_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [REP_W-1:0] rep_q, rep_d;
    logic [LEN_W-1:0] len_c;
    logic             out_d, valid_d, busy_d, done_d;

    // Shift-based select keeps the index width independent of PAT_W.
    function automatic logic pick(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] i);
        logic [PAT_W-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    assign len_c = LEN_W'(clamp_len(32'(len), 32'(PAT_W)));

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        lc_d    = lc_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        out_d   = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_c != '0) begin
                        pat_d   = pattern;
                        lc_d    = len_c;
                        rep_d   = reps;
                        idx_d   = len_c - 1'b1;
                        out_d   = pick(pattern, len_c - 1'b1);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = SHIFT;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end

            // abort outranks the final-bit transition, so it is tested first.
            SHIFT: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_q != '0) begin
                    idx_d   = idx_q - 1'b1;
                    out_d   = pick(pat_q, idx_q - 1'b1);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (rep_q != '0) begin
                    rep_d   = rep_q - 1'b1;
                    idx_d   = lc_q - 1'b1;
                    out_d   = pick(pat_q, lc_q - 1'b1);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            lc_q    <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            out     <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            lc_q    <= lc_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            out     <= out_d;
            valid   <= valid_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

endmodule
